// File: rtl/pwm_breathe_multi_if.sv
// Configuration and status bundle between the bus register file and pwm_breathe_multi.
// Signal names keep the _i/_o direction as seen from the PWM block.
interface pwm_breathe_multi_if #(
   parameter int Resolution = 16,
   parameter int Channels   = 4
);
   logic                           update_i;
   logic [Resolution-1:0]          period_i;
   logic [Resolution-1:0]          hold_i;
   logic [Channels-1:0]            enable_i;
   logic [Channels-1:0]            polarity_i;
   logic [2*Channels-1:0]          mode_i;
   logic [Resolution*Channels-1:0] duty_i;
   logic [Resolution*Channels-1:0] bound_lo_i;
   logic [Resolution*Channels-1:0] bound_hi_i;
   logic [Resolution*Channels-1:0] incr_i;
   logic [Channels-1:0]            pwm_o;
   logic [Resolution*Channels-1:0] cur_duty_o;
   logic                           period_end_o;
   logic                           pending_o;

   modport master (
      output update_i, period_i, hold_i, enable_i, polarity_i, mode_i,
             duty_i, bound_lo_i, bound_hi_i, incr_i,
      input  pwm_o, cur_duty_o, period_end_o, pending_o
   );

   modport slave (
      input  update_i, period_i, hold_i, enable_i, polarity_i, mode_i,
             duty_i, bound_lo_i, bound_hi_i, incr_i,
      output pwm_o, cur_duty_o, period_end_o, pending_o
   );
endinterface

// File: rtl/pwm_breathe_multi.sv
// Multi-channel PWM with a shared period counter, per-channel off/standard/breathe/ramp
// modes and double-buffered configuration applied only at period boundaries.
module pwm_breathe_multi #(
   parameter int Resolution = 16,
   parameter int Channels   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   pwm_breathe_multi_if.slave    bus
);
   localparam int R = Resolution;

   typedef logic [R-1:0] val_t;

   localparam logic [1:0] MODE_OFF     = 2'b00;
   localparam logic [1:0] MODE_BREATHE = 2'b10;
   localparam logic [1:0] MODE_RAMP    = 2'b11;

   val_t cnt_q, cnt_d;
   val_t period_sh_q;
   val_t hold_sh_q;
   val_t hold_cnt_q, hold_cnt_d;
   logic pending_q, pending_d;
   logic period_end;
   logic load;
   logic step;

   val_t cur_arr [Channels];
   logic pwm_arr [Channels];

   // Gated by rst_ni so the pulse drops immediately while reset is asserted.
   assign period_end = rst_ni & (cnt_q == period_sh_q);
   assign load       = period_end & (pending_q | bus.update_i);
   assign step       = period_end & ~load & (hold_cnt_q == hold_sh_q);

   always_comb begin
      cnt_d      = cnt_q + R'(1);
      hold_cnt_d = hold_cnt_q;
      pending_d  = pending_q;
      if (period_end) begin
         cnt_d = '0;
      end
      if (load || step) begin
         hold_cnt_d = '0;
      end else if (period_end) begin
         hold_cnt_d = hold_cnt_q + R'(1);
      end
      if (load) begin
         pending_d = 1'b0;
      end else if (bus.update_i) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q       <= '0;
         period_sh_q <= '0;
         hold_sh_q   <= '0;
         hold_cnt_q  <= '0;
         pending_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         hold_cnt_q <= hold_cnt_d;
         pending_q  <= pending_d;
         if (load) begin
            period_sh_q <= bus.period_i;
            hold_sh_q   <= bus.hold_i;
         end
      end
   end

   for (genvar gi = 0; gi < Channels; gi++) begin : g_ch
      val_t       a_in, b_in, duty_in, incr_in;
      val_t       lo_in, hi_in;
      logic [1:0] mode_in;

      logic       en_sh_q;
      logic       pol_sh_q;
      logic [1:0] mode_sh_q;
      val_t       lo_sh_q;
      val_t       hi_sh_q;
      val_t       incr_sh_q;
      val_t       cur_q, cur_d;
      logic       dir_q, dir_d;
      logic       pwm_q, pwm_d;
      logic [R:0] sum;
      logic [R:0] diff;

      assign a_in    = bus.bound_lo_i[gi*R +: R];
      assign b_in    = bus.bound_hi_i[gi*R +: R];
      assign duty_in = bus.duty_i[gi*R +: R];
      assign incr_in = bus.incr_i[gi*R +: R];
      assign mode_in = bus.mode_i[gi*2 +: 2];
      assign lo_in   = (a_in < b_in) ? a_in : b_in;
      assign hi_in   = (a_in < b_in) ? b_in : a_in;

      // One extra bit so the sweep arithmetic cannot wrap past the bounds.
      assign sum  = {1'b0, cur_q} + {1'b0, incr_sh_q};
      assign diff = {1'b0, cur_q} - {1'b0, lo_sh_q};

      always_comb begin
         cur_d = cur_q;
         dir_d = dir_q;
         if (load) begin
            dir_d = 1'b0;
            if (mode_in == MODE_BREATHE || mode_in == MODE_RAMP) begin
               cur_d = lo_in;
            end else begin
               cur_d = duty_in;
            end
         end else if (step) begin
            case (mode_sh_q)
               MODE_BREATHE: begin
                  if (!dir_q) begin
                     if (sum >= {1'b0, hi_sh_q}) begin
                        cur_d = hi_sh_q;
                        dir_d = 1'b1;
                     end else begin
                        cur_d = sum[R-1:0];
                     end
                  end else begin
                     if (diff <= {1'b0, incr_sh_q}) begin
                        cur_d = lo_sh_q;
                        dir_d = 1'b0;
                     end else begin
                        cur_d = cur_q - incr_sh_q;
                     end
                  end
               end
               MODE_RAMP: begin
                  if (sum > {1'b0, hi_sh_q}) begin
                     cur_d = lo_sh_q;
                  end else begin
                     cur_d = sum[R-1:0];
                  end
               end
               default: begin
                  cur_d = cur_q;
               end
            endcase
         end
      end

      always_comb begin
         pwm_d = pol_sh_q;
         if (en_sh_q && mode_sh_q != MODE_OFF) begin
            pwm_d = (cnt_q < cur_q) ^ pol_sh_q;
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            en_sh_q   <= 1'b0;
            pol_sh_q  <= 1'b0;
            mode_sh_q <= MODE_OFF;
            lo_sh_q   <= '0;
            hi_sh_q   <= '0;
            incr_sh_q <= '0;
            cur_q     <= '0;
            dir_q     <= 1'b0;
            pwm_q     <= 1'b0;
         end else begin
            cur_q <= cur_d;
            dir_q <= dir_d;
            pwm_q <= pwm_d;
            if (load) begin
               en_sh_q   <= bus.enable_i[gi];
               pol_sh_q  <= bus.polarity_i[gi];
               mode_sh_q <= mode_in;
               lo_sh_q   <= lo_in;
               hi_sh_q   <= hi_in;
               incr_sh_q <= incr_in;
            end
         end
      end

      assign cur_arr[gi] = cur_q;
      assign pwm_arr[gi] = pwm_q;
   end

   always_comb begin
      bus.pwm_o      = '0;
      bus.cur_duty_o = '0;
      for (int i = 0; i < Channels; i++) begin
         bus.pwm_o[i]            = pwm_arr[i];
         bus.cur_duty_o[i*R +: R] = cur_arr[i];
      end
   end

   assign bus.period_end_o = period_end;
   assign bus.pending_o    = pending_q;

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Directed bench for pwm_breathe_multi: expected values are queued when stimulus is
// driven and popped as the DUT produces the corresponding outputs.
module tb_pwm_breathe_multi;
   localparam int RES = 16;
   localparam int CH  = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];

   pwm_breathe_multi_if #(.Resolution(RES), .Channels(CH)) bus ();

   pwm_breathe_multi #(.Resolution(RES), .Channels(CH)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [63:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty: observed %0h expected a queued entry", obs);
      end else begin
         e = sb.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   function automatic logic [RES-1:0] cur(input int ch);
      return bus.cur_duty_o[ch*RES +: RES];
   endfunction

   task automatic set_ch(input int ch, input logic [1:0] mode, input logic [RES-1:0] duty,
                         input logic [RES-1:0] a, input logic [RES-1:0] b,
                         input logic [RES-1:0] incr, input logic en, input logic pol);
      bus.mode_i[ch*2 +: 2]       = mode;
      bus.duty_i[ch*RES +: RES]   = duty;
      bus.bound_lo_i[ch*RES +: RES] = a;
      bus.bound_hi_i[ch*RES +: RES] = b;
      bus.incr_i[ch*RES +: RES]   = incr;
      bus.enable_i[ch]            = en;
      bus.polarity_i[ch]          = pol;
   endtask

   task automatic clear_all();
      for (int c = 0; c < CH; c++) set_ch(c, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic wait_pe(input string tag);
      int n;
      n = 0;
      while (!bus.period_end_o && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_pe_reached"}, bus.period_end_o, 1);
   endtask

   // Raise update_i on a period_end cycle: it must apply there with pending never rising.
   task automatic apply_at_boundary(input string tag);
      wait_pe(tag);
      check({tag, "_pending_before"}, bus.pending_o, 0);
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      check({tag, "_pending_after"}, bus.pending_o, 0);
   endtask

   initial begin
      int b_seq[8];
      int r_seq[8];
      int t4_seq[6];
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.update_i = 1'b0;
      bus.period_i = '0;
      bus.hold_i   = '0;
      clear_all();
      #1;
      check("reset_pwm",     bus.pwm_o, 0);
      check("reset_pe",      bus.period_end_o, 0);
      check("reset_pending", bus.pending_o, 0);
      check("reset_cur",     bus.cur_duty_o, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Standard mode, duty 3 of 10
      bus.period_i = 16'd9;
      bus.hold_i   = 16'd0;
      set_ch(0, 2'b01, 16'd3, '0, '0, '0, 1'b1, 1'b0);
      apply_at_boundary("t2_load");
      check("t2_cur0", cur(0), 3);
      wait_pe("t2");
      for (int k = 1; k <= 20; k++) begin
         push("t2_pwm0", (((k - 2 + 10) % 10) < 3) ? 1 : 0);
         push("t2_pe",   (((k - 1) % 10) == 9) ? 1 : 0);
      end
      for (int k = 1; k <= 20; k++) begin
         tick();
         pop_check(bus.pwm_o[0]);
         pop_check(bus.period_end_o);
      end

      // Mid-period duty change 3 -> 7
      repeat (3) tick();
      check("t3_pe_mid", bus.period_end_o, 0);
      set_ch(0, 2'b01, 16'd7, '0, '0, '0, 1'b1, 1'b0);
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      check("t3_pending_set", bus.pending_o, 1);
      for (int k = 1; k <= 17; k++) begin
         int cnt_now;
         int cnt_prev;
         int duty;
         cnt_now  = (3 + k) % 10;
         cnt_prev = (2 + k) % 10;
         duty     = (k <= 7) ? 3 : 7;
         push("t3_pwm0",    (cnt_prev < duty) ? 1 : 0);
         push("t3_pe",      (cnt_now == 9) ? 1 : 0);
         push("t3_pending", (k <= 6) ? 1 : 0);
      end
      for (int k = 1; k <= 17; k++) begin
         tick();
         pop_check(bus.pwm_o[0]);
         pop_check(bus.period_end_o);
         pop_check(bus.pending_o);
      end
      check("t3_cur0", cur(0), 7);

      // Breathe 2..6 step 2
      clear_all();
      bus.period_i = 16'd3;
      bus.hold_i   = 16'd0;
      set_ch(0, 2'b10, '0, 16'd6, 16'd2, 16'd2, 1'b1, 1'b0);
      t4_seq = '{2, 4, 6, 4, 2, 4};
      foreach (t4_seq[i]) push("t4_breathe", t4_seq[i]);
      apply_at_boundary("t4_load");
      pop_check(cur(0));
      for (int i = 1; i < 6; i++) begin
         wait_pe("t4");
         tick();
         pop_check(cur(0));
      end

      // Breathe on ch0 and ramp on ch1, bounds 1..10 step 4
      clear_all();
      bus.period_i = 16'd3;
      bus.hold_i   = 16'd0;
      set_ch(0, 2'b10, '0, 16'd10, 16'd1, 16'd4, 1'b1, 1'b0);
      set_ch(1, 2'b11, '0, 16'd1, 16'd10, 16'd4, 1'b1, 1'b0);
      b_seq = '{1, 5, 9, 10, 6, 2, 1, 5};
      r_seq = '{1, 5, 9, 1, 5, 9, 1, 5};
      for (int i = 0; i < 8; i++) begin
         push("t5_breathe", b_seq[i]);
         push("t5_ramp",    r_seq[i]);
      end
      apply_at_boundary("t5_load");
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            wait_pe("t5");
            tick();
         end
         pop_check(cur(0));
         pop_check(cur(1));
      end

      // Same sweeps with a step every second period
      bus.hold_i = 16'd1;
      b_seq = '{1, 1, 5, 5, 9, 9, 10, 10};
      r_seq = '{1, 1, 5, 5, 9, 9, 1, 1};
      for (int i = 0; i < 8; i++) begin
         push("t5h_breathe", b_seq[i]);
         push("t5h_ramp",    r_seq[i]);
      end
      apply_at_boundary("t5h_load");
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            wait_pe("t5h");
            tick();
         end
         pop_check(cur(0));
         pop_check(cur(1));
      end

      // Polarity, saturation and disabled channels
      clear_all();
      bus.period_i = 16'd9;
      bus.hold_i   = 16'd0;
      set_ch(0, 2'b01, 16'd0,  '0, '0, '0, 1'b1, 1'b1);
      set_ch(1, 2'b01, 16'd20, '0, '0, '0, 1'b1, 1'b0);
      set_ch(2, 2'b01, 16'd5,  '0, '0, '0, 1'b0, 1'b1);
      set_ch(3, 2'b01, 16'd5,  '0, '0, '0, 1'b0, 1'b0);
      apply_at_boundary("t6_load");
      check("t6_cur2_disabled", cur(2), 5);
      tick();
      for (int k = 0; k < 12; k++) push("t6_pwm", 4'b0111);
      for (int k = 0; k < 12; k++) begin
         pop_check(bus.pwm_o);
         tick();
      end

      // Asynchronous reset while pwm, period_end and pending are all high
      bus.update_i = 1'b1;
      tick();
      bus.update_i = 1'b0;
      check("t1_pending_pre", bus.pending_o, 1);
      wait_pe("t1");
      check("t1_pwm0_pre",    bus.pwm_o[0], 1);
      check("t1_pending_hold", bus.pending_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_pwm",     bus.pwm_o, 0);
      check("t1_pe",      bus.period_end_o, 0);
      check("t1_pending", bus.pending_o, 0);
      check("t1_cur",     bus.cur_duty_o, 0);
      tick();
      rst_n = 1'b1;
      tick();

      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pwm_breathe_multi.md
Name: pwm_breathe_multi

Overview:
- Multi-channel PWM generator with a shared period counter and per-channel modes: off, standard (fixed duty), breathe (triangle duty sweep between two bounds) and ramp (sawtooth duty sweep).
- All configuration is double-buffered. A software update request is applied only at a PWM period boundary, so outputs never glitch mid-period.
- Sits in the peripheral subsystem behind the bus register file, which drives the flattened configuration buses.

Parameters:
- Resolution, 16, width of the period, duty, bound and increment values.
- Channels, 4, number of independent PWM outputs.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- update_i  input  1  single-cycle request to load all config inputs into the shadow registers at the next period end
- period_i  input  Resolution  PWM period is period_i+1 cycles
- hold_i  input  Resolution  sweep step taken every hold_i+1 PWM periods
- enable_i  input  Channels  per-channel enable
- polarity_i  input  Channels  1 = inverted output
- mode_i  input  2*Channels  per channel: 00 off, 01 standard, 10 breathe, 11 ramp
- duty_i  input  Resolution*Channels  standard-mode duty in cycles
- bound_lo_i  input  Resolution*Channels  sweep bound A
- bound_hi_i  input  Resolution*Channels  sweep bound B
- incr_i  input  Resolution*Channels  sweep increment per step
- pwm_o  output  Channels  registered PWM outputs
- cur_duty_o  output  Resolution*Channels  duty currently in effect, per channel
- period_end_o  output  1  one-cycle pulse on the last cycle of each period
- pending_o  output  1  update requested but not yet applied

Behaviour:
- Reset (asynchronous, rst_ni=0): all counters, shadows, direction bits, cur_duty_o, pwm_o, period_end_o and pending_o go to 0.
- Period counter
  - Counts 0..period_sh and wraps to 0.
  - period_end_o = (cnt==period_sh), combinational from registered state.
  - With period_sh=0, period_end_o is high every cycle.
- Update handshake
  - update_i sets pending_o from the next cycle.
  - On a cycle with period_end_o=1 and (pending_o or update_i): all shadows load from the inputs sampled that cycle, and pending clears.
  - update_i coincident with period end is applied at that same boundary.
  - Extra update_i pulses while pending are merged; the inputs sampled at the boundary win.
- Shadow load, per channel
  - lo_sh = min(A,B), hi_sh = max(A,B).
  - Standard mode: cur = duty.
  - Breathe and ramp modes: cur = lo_sh, direction = up.
  - The hold counter resets to 0.
- Sweep step event: occurs on a period end where hold_cnt==hold_sh; hold_cnt then clears, otherwise it increments on each period end. No step event occurs on a boundary where a shadow load happens.
- Breathe step, sums computed in Resolution+1 bits:
  - Up: if cur+incr >= hi then cur=hi, direction=down; else cur += incr.
  - Down: if cur-lo <= incr then cur=lo, direction=up; else cur -= incr.
- Ramp step: if cur+incr > hi then cur=lo; else cur += incr.
- Degenerate cases
  - incr=0: cur stays constant.
  - lo==hi: cur stays at lo.
- cur changes only at period end and takes effect from the next period's cnt=0.
- Output
  - raw = (cnt < cur).
  - pwm_o <= (enable_sh & mode_sh!=00) ? raw ^ pol_sh : pol_sh, giving 1 cycle latency from cnt.
  - cur=0 gives always inactive; cur > period_sh gives always active.
- Off or disabled channel: output held at its idle level (pol_sh); cur_duty_o still reports cur.

Test Plan:
1. Reset mid-period with pwm_o high → pwm_o, period_end_o, pending_o and cur_duty_o drop to 0 immediately (asynchronous), before any clock edge.
2. Standard mode, ch0, period_i=9, duty=3, update_i pulsed once → after the first period end, pwm_o[0] is high for 3 of every 10 cycles, starting 1 cycle after cnt=0; period_end_o pulses every 10 cycles.
3. Update while running: duty changed 3→7 with update_i pulsed mid-period → pending_o=1 until the period end; the current period completes with duty 3 and the next period uses 7; no short or extra pulse.
4. Breathe, period_i=3, hold_i=0, A=6, B=2, incr=2 → cur_duty_o sequence per period: 2,4,6,4,2,4…; direction reverses exactly at 6 and at 2.
5. Breathe, lo=1, hi=10, incr=4 → 1,5,9,10,6,2,1,5 (saturates at both bounds). Ramp with the same values → 1,5,9,1,5.
6. Polarity and edge cases: polarity=1, duty=0 → pwm_o constantly 1; duty=20 with period_i=9, polarity=0 → constantly 1. enable=0 → pwm_o equals the polarity level. update_i on the same cycle as period_end_o → applied at that boundary, and pending_o never rises.
